// File: rtl/timing_ir_sequencer_pkg.sv
// Shared constants for the 6502C cycle-timing generator and instruction register.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
package timing_ir_sequencer_pkg;

  // One-hot cycle states; exactly one bit is set at all times.
  typedef enum logic [6:0] {
    T0 = 7'b000_0001,
    T1 = 7'b000_0010,
    T2 = 7'b000_0100,
    T3 = 7'b000_1000,
    T4 = 7'b001_0000,
    T5 = 7'b010_0000,
    T6 = 7'b100_0000
  } t_state_e;

  // activeInt encodings: [2]=RST [1]=NMI [0]=IRQ.
  localparam logic [2:0] INT_NONE = 3'b000;
  localparam logic [2:0] INT_IRQ  = 3'b001;
  localparam logic [2:0] INT_NMI  = 3'b010;
  localparam logic [2:0] INT_RST  = 3'b100;

  localparam logic [7:0] OP_BRK = 8'h00;
  localparam logic [7:0] OP_NOP = 8'hEA;

  // KIL opcodes: x2 with upper nibble 0-7, 9, B, D, F (i.e. not 8, A, C, E).
  function automatic logic is_kil(input logic [7:0] op);
    return (op[3:0] == 4'h2) && (!op[7] || op[4]);
  endfunction

endpackage

// File: rtl/timing_ir_sequencer_nmi.sv
// NMI falling-edge detector with a sticky pending flag and a clear input.
// Latency: pend_o rises one cycle after the clock edge that sees nmi_n_i low following high.
// Backpressure: none; runs every cycle regardless of rdy, and a new edge wins over clr_i.
module nmi_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic nmi_n_i,
  input  logic clr_i,
  output logic pend_o
);

  logic nmi_q;
  logic pend_q, pend_d;
  logic fall;

  assign fall   = nmi_q & ~nmi_n_i;
  assign pend_d = fall | (pend_q & ~clr_i);
  assign pend_o = pend_q;

  // Track the previous nmi_n level; reset seeds it with the live level so a line
  // held low through reset does not look like a fresh edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      nmi_q  <= nmi_n_i;
      pend_q <= 1'b0;
    end else begin
      nmi_q  <= nmi_n_i;
      pend_q <= pend_d;
    end
  end

endmodule

// File: rtl/timing_ir_sequencer.sv
// 6502C cycle-timing generator, instruction register, previous-opcode register and interrupt arbiter.
// Latency: OP/prevOP/activeInt update at the T1 fetch edge (valid in T2); T advances one state per rdy cycle.
// Backpressure: rdy=0 freezes T, OP, prevOP, activeInt and the sampled interrupt; NMI edges are still captured.
// Optional: define TIMING_KIL_EN to halt on KIL opcodes; otherwise halted is tied 0.
module timing_ir_sequencer
  import timing_ir_sequencer_pkg::*;
#(
  parameter logic [7:0] BRK_OP   = OP_BRK,
  parameter logic [7:0] RESET_OP = OP_NOP
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rdy,
  input  logic [7:0] din,
  input  logic       last_cycle,
  input  logic       skip_cycle,
  input  logic       flag_i,
  input  logic       nmi_n,
  input  logic       irq_n,
  output logic [6:0] T,
  output logic [7:0] OP,
  output logic [7:0] prevOP,
  output logic [2:0] activeInt,
  output logic       sync,
  output logic       halted
);

  t_state_e   t_q, t_d;
  logic [7:0] op_q, prev_q;
  logic [2:0] act_q;
  logic [2:0] src_q, src_next;   // interrupt chosen at the last-cycle edge, one-hot or zero
  logic       rst_pend_q;
  logic       nmi_pend;
  logic       halted_w;
  logic       kil_hit;
  logic       fetch;
  logic       load_src;

  assign fetch    = rdy && !halted_w && (t_q == T1);
  // Entering T1 means the previous instruction (or reset's T0) just ended.
  assign load_src = (t_q != T1) && (t_d == T1);

  assign src_next = rst_pend_q            ? INT_RST :
                    nmi_pend              ? INT_NMI :
                    (!irq_n && !flag_i)   ? INT_IRQ : INT_NONE;

  nmi_edge_detect u_nmi (
    .clk    (clk),
    .rst    (rst),
    .nmi_n_i(nmi_n),
    .clr_i  (fetch && (src_q == INT_NMI)),
    .pend_o (nmi_pend)
  );

`ifdef TIMING_KIL_EN
  logic halted_q;
  // An interrupt fetch forces BRK, so only a genuinely fetched KIL opcode halts.
  assign kil_hit  = (src_q == INT_NONE) && is_kil(din);
  assign halted_w = halted_q;

  // Sticky halt flag, left only through reset.
  always_ff @(posedge clk) begin
    if (rst)                   halted_q <= 1'b0;
    else if (fetch && kil_hit) halted_q <= 1'b1;
  end
`else
  assign kil_hit  = 1'b0;
  assign halted_w = 1'b0;
`endif

  // Cycle-state register.
  always_ff @(posedge clk) begin
    if (rst) t_q <= T0;
    else     t_q <= t_d;
  end

  // Next cycle state: last_cycle beats skip_cycle, skips saturate at T6, T6 always exits.
  always_comb begin
    t_d = t_q;
    if (rdy && !halted_w) begin
      case (t_q)
        T0:      t_d = T1;
        T1:      t_d = kil_hit ? T0 : T2;
        T2:      t_d = last_cycle ? T1 : (skip_cycle ? T4 : T3);
        T3:      t_d = last_cycle ? T1 : (skip_cycle ? T5 : T4);
        T4:      t_d = last_cycle ? T1 : (skip_cycle ? T6 : T5);
        T5:      t_d = last_cycle ? T1 : T6;
        T6:      t_d = T1;
        default: t_d = T0;
      endcase
    end
  end

  // Instruction register, previous-opcode register and interrupt arbitration.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q       <= 8'h00;
      prev_q     <= RESET_OP;
      act_q      <= INT_NONE;
      src_q      <= INT_NONE;
      rst_pend_q <= 1'b1;
    end else begin
      if (load_src) src_q <= src_next;
      if (fetch) begin
        // The reset BRK follows no real instruction, so nothing may be written back.
        prev_q <= (src_q == INT_RST) ? RESET_OP : op_q;
        op_q   <= (src_q != INT_NONE) ? BRK_OP : din;
        act_q  <= src_q;
        if (src_q == INT_RST) rst_pend_q <= 1'b0;
      end
    end
  end

  assign T         = t_q;
  assign OP        = op_q;
  assign prevOP    = prev_q;
  assign activeInt = act_q;
  assign sync      = (t_q == T1);
  assign halted    = halted_w;

endmodule

// File: tb/tb_timing_ir_sequencer.sv
module tb_timing_ir_sequencer;

  localparam logic [6:0] E_T0 = 7'b000_0001;
  localparam logic [6:0] E_T1 = 7'b000_0010;
  localparam logic [6:0] E_T2 = 7'b000_0100;
  localparam logic [6:0] E_T3 = 7'b000_1000;
  localparam logic [6:0] E_T4 = 7'b001_0000;
  localparam logic [6:0] E_T5 = 7'b010_0000;
  localparam logic [6:0] E_T6 = 7'b100_0000;

  typedef struct packed {
    logic [6:0] t;
    logic [7:0] op;
    logic [7:0] pop;
    logic [2:0] ai;
    logic       sync;
    logic       halt;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst, rdy, last_cycle, skip_cycle, flag_i, nmi_n, irq_n;
  logic [7:0] din;
  logic [6:0] T;
  logic [7:0] OP, prevOP;
  logic [2:0] activeInt;
  logic       sync, halted;

  obs_t  exp_q[$];
  obs_t  obs_q[$];
  string tag_q[$];
  int    tests = 0;
  int    fails = 0;

  timing_ir_sequencer dut (
    .clk(clk), .rst(rst), .rdy(rdy), .din(din), .last_cycle(last_cycle),
    .skip_cycle(skip_cycle), .flag_i(flag_i), .nmi_n(nmi_n), .irq_n(irq_n),
    .T(T), .OP(OP), .prevOP(prevOP), .activeInt(activeInt), .sync(sync), .halted(halted)
  );

  always #5 clk = ~clk;

  // Monitor: capture DUT outputs 1 time unit after every rising edge.
  always @(posedge clk) begin
    #1;
    obs_q.push_back('{t: T, op: OP, pop: prevOP, ai: activeInt, sync: sync, halt: halted});
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  // Drive one cycle of inputs and record what the outputs must be after the edge.
  task automatic drv(input logic r, input logic rd, input logic lc, input logic sk,
                     input logic [7:0] d, input string tag, input logic [6:0] et,
                     input logic [7:0] eop, input logic [7:0] epop, input logic [2:0] eai,
                     input logic eh);
    rst = r; rdy = rd; last_cycle = lc; skip_cycle = sk; din = d;
    exp_q.push_back('{t: et, op: eop, pop: epop, ai: eai, sync: (et == E_T1), halt: eh});
    tag_q.push_back(tag);
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    obs_t e, o; string n;
    obs_q.delete();
    drv(1, 1, 0, 0, 8'hA9, "rst0",      E_T0, 8'h00, 8'hEA, 3'b000, 0);
    drv(1, 1, 1, 1, 8'hA9, "rst1",      E_T0, 8'h00, 8'hEA, 3'b000, 0);
    drv(0, 1, 0, 0, 8'hA9, "t0_to_t1",  E_T1, 8'h00, 8'hEA, 3'b000, 0);
    drv(0, 1, 0, 0, 8'hA9, "rst_fetch", E_T2, 8'h00, 8'hEA, 3'b100, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n = tag_q.pop_front(); tests++;
      if (obs_q.size() == 0) begin fails++; $display("FAIL %s: no sample, expected %h", n, e); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          fails++;
          $display("FAIL %s: got T=%b OP=%h prevOP=%h act=%b sync=%b halt=%b, expected T=%b OP=%h prevOP=%h act=%b sync=%b halt=%b",
                   n, o.t, o.op, o.pop, o.ai, o.sync, o.halt, e.t, e.op, e.pop, e.ai, e.sync, e.halt);
        end
      end
    end
  endtask

  task automatic test_two_cycle();
    obs_t e, o; string n;
    obs_q.delete();
    drv(0, 1, 1, 0, 8'hE8, "brk_last",  E_T1, 8'h00, 8'hEA, 3'b100, 0);
    drv(0, 1, 0, 0, 8'hE8, "fetch_inx", E_T2, 8'hE8, 8'h00, 3'b000, 0);
    drv(0, 1, 1, 0, 8'hC8, "inx_last",  E_T1, 8'hE8, 8'h00, 3'b000, 0);
    drv(0, 1, 0, 0, 8'hC8, "fetch_iny", E_T2, 8'hC8, 8'hE8, 3'b000, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n = tag_q.pop_front(); tests++;
      if (obs_q.size() == 0) begin fails++; $display("FAIL %s: no sample, expected %h", n, e); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          fails++;
          $display("FAIL %s: got T=%b OP=%h prevOP=%h act=%b sync=%b halt=%b, expected T=%b OP=%h prevOP=%h act=%b sync=%b halt=%b",
                   n, o.t, o.op, o.pop, o.ai, o.sync, o.halt, e.t, e.op, e.pop, e.ai, e.sync, e.halt);
        end
      end
    end
  endtask

  task automatic test_skip();
    obs_t e, o; string n;
    obs_q.delete();
    drv(0, 1, 0, 1, 8'h4C, "skip_t2",        E_T4, 8'hC8, 8'hE8, 3'b000, 0);
    drv(0, 1, 0, 0, 8'h4C, "t4_to_t5",       E_T5, 8'hC8, 8'hE8, 3'b000, 0);
    drv(0, 1, 0, 1, 8'h4C, "skip_t5_sat",    E_T6, 8'hC8, 8'hE8, 3'b000, 0);
    drv(0, 1, 0, 0, 8'h4C, "t6_forced",      E_T1, 8'hC8, 8'hE8, 3'b000, 0);
    drv(0, 1, 1, 0, 8'h4C, "fetch_last_ign", E_T2, 8'h4C, 8'hC8, 3'b000, 0);
    drv(0, 1, 1, 1, 8'hEA, "last_over_skip", E_T1, 8'h4C, 8'hC8, 3'b000, 0);
    drv(0, 1, 0, 1, 8'hEA, "fetch_skip_ign", E_T2, 8'hEA, 8'h4C, 3'b000, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n = tag_q.pop_front(); tests++;
      if (obs_q.size() == 0) begin fails++; $display("FAIL %s: no sample, expected %h", n, e); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          fails++;
          $display("FAIL %s: got T=%b OP=%h prevOP=%h act=%b sync=%b halt=%b, expected T=%b OP=%h prevOP=%h act=%b sync=%b halt=%b",
                   n, o.t, o.op, o.pop, o.ai, o.sync, o.halt, e.t, e.op, e.pop, e.ai, e.sync, e.halt);
        end
      end
    end
  endtask

  task automatic test_interrupts();
    obs_t e, o; string n;
    obs_q.delete();
    irq_n = 1'b0; flag_i = 1'b1;
    drv(0, 1, 1, 0, 8'hA2, "irq_masked_last",  E_T1, 8'hEA, 8'h4C, 3'b000, 0);
    drv(0, 1, 0, 0, 8'hA2, "irq_masked_fetch", E_T2, 8'hA2, 8'hEA, 3'b000, 0);
    flag_i = 1'b0; nmi_n = 1'b0;
    drv(0, 1, 0, 0, 8'hA2, "nmi_edge",         E_T3, 8'hA2, 8'hEA, 3'b000, 0);
    drv(0, 1, 1, 0, 8'hA2, "nmi_last",         E_T1, 8'hA2, 8'hEA, 3'b000, 0);
    drv(0, 1, 0, 0, 8'hA2, "nmi_fetch",        E_T2, 8'h00, 8'hA2, 3'b010, 0);
    drv(0, 1, 1, 0, 8'hA2, "irq_last",         E_T1, 8'h00, 8'hA2, 3'b010, 0);
    drv(0, 1, 0, 0, 8'hA2, "irq_fetch",        E_T2, 8'h00, 8'h00, 3'b001, 0);
    nmi_n = 1'b1;
    drv(0, 1, 0, 0, 8'hA2, "irq_hold",         E_T3, 8'h00, 8'h00, 3'b001, 0);
    irq_n = 1'b1;
    drv(0, 1, 1, 0, 8'hA2, "irq_drop_last",    E_T1, 8'h00, 8'h00, 3'b001, 0);
    drv(0, 1, 0, 0, 8'hA2, "irq_drop_fetch",   E_T2, 8'hA2, 8'h00, 3'b000, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n = tag_q.pop_front(); tests++;
      if (obs_q.size() == 0) begin fails++; $display("FAIL %s: no sample, expected %h", n, e); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          fails++;
          $display("FAIL %s: got T=%b OP=%h prevOP=%h act=%b sync=%b halt=%b, expected T=%b OP=%h prevOP=%h act=%b sync=%b halt=%b",
                   n, o.t, o.op, o.pop, o.ai, o.sync, o.halt, e.t, e.op, e.pop, e.ai, e.sync, e.halt);
        end
      end
    end
  endtask

  task automatic test_stall();
    obs_t e, o; string n;
    obs_q.delete();
    drv(0, 1, 0, 0, 8'hE8, "to_t3",           E_T3, 8'hA2, 8'h00, 3'b000, 0);
    nmi_n = 1'b0;
    drv(0, 0, 1, 1, 8'hE8, "stall0",          E_T3, 8'hA2, 8'h00, 3'b000, 0);
    nmi_n = 1'b1;
    drv(0, 0, 1, 0, 8'hE8, "stall1",          E_T3, 8'hA2, 8'h00, 3'b000, 0);
    drv(0, 0, 0, 0, 8'hE8, "stall2",          E_T3, 8'hA2, 8'h00, 3'b000, 0);
    drv(0, 1, 1, 0, 8'hE8, "stall_last",      E_T1, 8'hA2, 8'h00, 3'b000, 0);
    drv(0, 1, 0, 0, 8'hE8, "stall_nmi_fetch", E_T2, 8'h00, 8'hA2, 3'b010, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n = tag_q.pop_front(); tests++;
      if (obs_q.size() == 0) begin fails++; $display("FAIL %s: no sample, expected %h", n, e); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          fails++;
          $display("FAIL %s: got T=%b OP=%h prevOP=%h act=%b sync=%b halt=%b, expected T=%b OP=%h prevOP=%h act=%b sync=%b halt=%b",
                   n, o.t, o.op, o.pop, o.ai, o.sync, o.halt, e.t, e.op, e.pop, e.ai, e.sync, e.halt);
        end
      end
    end
  endtask

  task automatic test_kil();
    obs_t e, o; string n;
    obs_q.delete();
    drv(0, 1, 1, 0, 8'h02, "pre_kil_last", E_T1, 8'h00, 8'hA2, 3'b010, 0);
`ifdef TIMING_KIL_EN
    drv(0, 1, 0, 0, 8'h02, "kil_fetch",    E_T0, 8'h02, 8'h00, 3'b000, 1);
    drv(0, 1, 1, 1, 8'hA9, "kil_hold",     E_T0, 8'h02, 8'h00, 3'b000, 1);
`else
    drv(0, 1, 0, 0, 8'h02, "kil_fetch",    E_T2, 8'h02, 8'h00, 3'b000, 0);
    drv(0, 1, 0, 0, 8'hA9, "kil_next",     E_T3, 8'h02, 8'h00, 3'b000, 0);
`endif
    drv(1, 1, 0, 0, 8'hA9, "kil_rst",      E_T0, 8'h00, 8'hEA, 3'b000, 0);
    drv(0, 1, 0, 0, 8'hA9, "rec_t1",       E_T1, 8'h00, 8'hEA, 3'b000, 0);
    drv(0, 1, 0, 0, 8'hA9, "rec_fetch",    E_T2, 8'h00, 8'hEA, 3'b100, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); n = tag_q.pop_front(); tests++;
      if (obs_q.size() == 0) begin fails++; $display("FAIL %s: no sample, expected %h", n, e); end
      else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          fails++;
          $display("FAIL %s: got T=%b OP=%h prevOP=%h act=%b sync=%b halt=%b, expected T=%b OP=%h prevOP=%h act=%b sync=%b halt=%b",
                   n, o.t, o.op, o.pop, o.ai, o.sync, o.halt, e.t, e.op, e.pop, e.ai, e.sync, e.halt);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; din = 8'hA9; last_cycle = 1'b0; skip_cycle = 1'b0;
    flag_i = 1'b0; nmi_n = 1'b1; irq_n = 1'b1;
    test_reset();
    test_two_cycle();
    test_skip();
    test_interrupts();
    test_stall();
    test_kil();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
